// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state encoding and nibble width for the serial adder
package adder_pkg;

   // Width of the single adder slice; the operand is walked one slice at a time
   localparam int NIBBLE_W = 4;

   // Sequencer states: waiting for operands, stepping nibbles, holding the result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder4_slice.sv
// rtl/adder4_slice.sv - combinational 4-bit adder slice with carry in and carry out
module adder4_slice
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] total;

   // Widen by one bit so the carry-out falls out of the top of the addition
   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
      sum   = total[NIBBLE_W-1:0];
      cout  = total[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - serial WIDTH-bit adder stepping one nibble per clock
module nibble_add_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIB  = WIDTH / NIBBLE_W;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic [IDXW-1:0]  idx_q;
   logic [IDXW-1:0]  idx_d;
   logic             carry_q;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [WIDTH-1:0]    a_sh;
   logic [WIDTH-1:0]    b_sh;
   logic [WIDTH-1:0]    nib_ins;
   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

   // Pick nibble idx of each captured operand and position the slice result at the same nibble;
   // {idx, 2'b00} is idx*4, the bit offset of the current nibble
   always_comb begin
      a_sh    = a_q >> {idx_q, 2'b00};
      b_sh    = b_q >> {idx_q, 2'b00};
      slice_a = a_sh[NIBBLE_W-1:0];
      slice_b = b_sh[NIBBLE_W-1:0];
      nib_ins = WIDTH'(slice_sum) << {idx_q, 2'b00};
      sum_d   = sum_q | nib_ins;
      idx_d   = idx_q + IDXW'(1);
   end

   adder4_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Sequencer: capture operands, ripple the carry through the register one nibble per edge, hold result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= cin;
                  idx_q      <= '0;
                  sum_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_q   <= sum_d;
               carry_q <= slice_cout;
               idx_q   <= idx_d;
               if (idx_q == IDX_LAST) begin
                  cout_q      <= slice_cout;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - scoreboard bench for the serial nibble adder at WIDTH 16 and 4
module tb_nibble_add_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        iv16, ir16, ov16, or16, cin16, cout16, busy16;
   logic [15:0] a16, b16, sum16;
   logic        iv4, ir4, ov4, or4, cin4, cout4, busy4;
   logic [3:0]  a4, b4, sum4;

   int checks = 0;
   int errors = 0;

   logic [16:0] q16[$];
   logic [4:0]  q4[$];

   nibble_add_seq #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .busy(busy16)
   );

   nibble_add_seq #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      iv16 = 0; or16 = 0; a16 = '0; b16 = '0; cin16 = 0;
      iv4 = 0; or4 = 0; a4 = '0; b4 = '0; cin4 = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ir16, ov16, busy16, cout16, sum16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset16 got ir=%b ov=%b busy=%b cout=%b sum=%h want ir=1 ov=0 busy=0 cout=0 sum=0000",
                  ir16, ov16, busy16, cout16, sum16);
      end
      checks++;
      if ({ir4, ov4, busy4, cout4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset4 got ir=%b ov=%b busy=%b cout=%b sum=%h want ir=1 ov=0 busy=0 cout=0 sum=0",
                  ir4, ov4, busy4, cout4, sum4);
      end
      rst_n = 1'b1;
   endtask

   // Starts just after a negedge with the 16-bit DUT idle; returns just after a negedge with it idle
   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input int stall, input bit early, input bit toggle, input string name);
      logic [16:0] exp;
      int n;
      checks++;
      if (ir16 !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready got %b want 1", name, ir16);
      end
      a16 = av; b16 = bv; cin16 = cv; iv16 = 1'b1; or16 = early;
      q16.push_back({1'b0, av} + {1'b0, bv} + {16'h0000, cv});
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      if (toggle) begin
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'b1;
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!ov16 && toggle) begin
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'($urandom);
         end
      end while (!ov16 && n < 20);
      iv16 = 1'b0;
      exp = q16.pop_front();
      checks++;
      if (n !== 4 || ov16 !== 1'b1) begin
         errors++;
         $display("FAIL %s latency got %0d edges (ov=%b) want 4", name, n, ov16);
         or16 = 1'b0;
         return;
      end
      checks++;
      if ({cout16, sum16} !== exp) begin
         errors++;
         $display("FAIL %s result got cout=%b sum=%h want cout=%b sum=%h", name, cout16, sum16, exp[16], exp[15:0]);
      end
      checks++;
      if (busy16 !== 1'b1 || ir16 !== 1'b0) begin
         errors++;
         $display("FAIL %s done_flags got busy=%b ir=%b want busy=1 ir=0", name, busy16, ir16);
      end
      if (!early) begin
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checks++;
            if (ov16 !== 1'b1 || ir16 !== 1'b0 || {cout16, sum16} !== exp) begin
               errors++;
               $display("FAIL %s stall%0d got ov=%b ir=%b cout=%b sum=%h want ov=1 ir=0 cout=%b sum=%h",
                        name, k, ov16, ir16, cout16, sum16, exp[16], exp[15:0]);
            end
         end
      end
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      checks++;
      if (ov16 !== 1'b0 || ir16 !== 1'b1 || busy16 !== 1'b0) begin
         errors++;
         $display("FAIL %s return_idle got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0", name, ov16, ir16, busy16);
      end
      checks++;
      if ({cout16, sum16} !== exp) begin
         errors++;
         $display("FAIL %s idle_hold got cout=%b sum=%h want cout=%b sum=%h", name, cout16, sum16, exp[16], exp[15:0]);
      end
   endtask

   task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
      logic [4:0] exp;
      int n;
      a4 = av; b4 = bv; cin4 = cv; iv4 = 1'b1; or4 = 1'b1;
      q4.push_back({1'b0, av} + {1'b0, bv} + {4'h0, cv});
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!ov4 && n < 10);
      exp = q4.pop_front();
      checks++;
      if (n !== 1 || ov4 !== 1'b1) begin
         errors++;
         $display("FAIL w4 latency a=%h b=%h cin=%b got %0d edges (ov=%b) want 1", av, bv, cv, n, ov4);
      end
      checks++;
      if ({cout4, sum4} !== exp) begin
         errors++;
         $display("FAIL w4 result a=%h b=%h cin=%b got cout=%b sum=%h want cout=%b sum=%h",
                  av, bv, cv, cout4, sum4, exp[4], exp[3:0]);
      end
      @(negedge clk);
      checks++;
      if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
         errors++;
         $display("FAIL w4 return_idle got ov=%b ir=%b want ov=0 ir=1", ov4, ir4);
      end
   endtask

   task automatic test_vectors16();
      run16(16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0, "zero");
      run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, "ripple");
      run16(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b0, "mixed_cin");
      run16(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b0, "msb_carry");
   endtask

   task automatic test_back_to_back();
      run16(16'hABCD, 16'h1357, 1'b1, 0, 1'b1, 1'b0, "ready_early");
      run16(16'h0F0F, 16'hF0F1, 1'b0, 0, 1'b1, 1'b0, "ready_early2");
   endtask

   task automatic test_stall_and_toggle();
      run16(16'h7FFF, 16'h0001, 1'b1, 3, 1'b0, 1'b0, "stall3");
      run16(16'hC3A5, 16'h5A3C, 1'b1, 2, 1'b0, 1'b1, "toggle_run");
   endtask

   task automatic test_reset_mid_run();
      a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; iv16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ir16, ov16, busy16, cout16, sum16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL mid_reset got ir=%b ov=%b busy=%b cout=%b sum=%h want ir=1 ov=0 busy=0 cout=0 sum=0000",
                  ir16, ov16, busy16, cout16, sum16);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run16(16'h0007, 16'h0009, 1'b0, 0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_width4();
      run4(4'd7, 4'd9, 1'b0);
      for (int i = 0; i < 512; i++) begin
         run4(i[3:0], i[7:4], i[8]);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_vectors16();
      test_back_to_back();
      test_stall_and_toggle();
      test_reset_mid_run();
      test_width4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
